// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO control unit: state encoding and geometry.
package fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;

    // Status FSM states; the encoding is fixed because other blocks decode it.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WR_ERR = 3'd2,
        READ   = 3'd3,
        RD_ERR = 3'd4,
        RW     = 3'd5
    } fifo_state_e;

endpackage

// File: rtl/fifo_fsm_out.sv
// Status FSM: remembers what happened to last cycle's requests and
// presents it as Moore ack/err flags for exactly one cycle.
module fifo_fsm_out
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic wa_i,
    input  logic ra_i,
    input  logic wr_en_i,
    input  logic rd_en_i,
    input  logic full_i,
    input  logic empty_i,
    output logic wr_ack_o,
    output logic wr_err_o,
    output logic rd_ack_o,
    output logic rd_err_o
);

    fifo_state_e state_q, state_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state by priority (accepted traffic outranks errors), plus Moore decode of the current state.
    always_comb begin
        state_d  = IDLE;
        wr_ack_o = 1'b0;
        wr_err_o = 1'b0;
        rd_ack_o = 1'b0;
        rd_err_o = 1'b0;

        if (wa_i && ra_i) begin
            state_d = RW;
        end else if (wa_i) begin
            state_d = WRITE;
        end else if (ra_i) begin
            state_d = READ;
        end else if (wr_en_i && full_i) begin
            state_d = WR_ERR;
        end else if (rd_en_i && empty_i) begin
            state_d = RD_ERR;
        end

        case (state_q)
            WRITE:   wr_ack_o = 1'b1;
            READ:    rd_ack_o = 1'b1;
            RW: begin
                wr_ack_o = 1'b1;
                rd_ack_o = 1'b1;
            end
            WR_ERR:  wr_err_o = 1'b1;
            RD_ERR:  rd_err_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fifo_ctrl8.sv
// FIFO control unit: write head, read tail and occupancy for the 8 x 32 register
// bank, one-hot write enables, registered read-mux select and status flags.
module fifo_ctrl8
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW,
    parameter int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [DEPTH-1:0] we,
    output logic [AW-1:0]    rd_sel,
    output logic [CW-1:0]    data_count,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err
);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] rd_sel_q, rd_sel_d;
    logic [CW-1:0] count_q, count_d;
    logic          wa;
    logic          ra;

    // Flags come from the registered count so accept decisions never chain through this cycle's requests.
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign wa         = wr_en & ~full;
    assign ra         = rd_en & ~empty;
    assign data_count = count_q;
    assign rd_sel     = rd_sel_q;

    // One-hot write enable at the head; held off during reset so a discarded write never lands.
    always_comb begin
        we = '0;
        if (wa && reset_n) begin
            we = DEPTH'(1) << head_q;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at AW bits.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        rd_sel_d = rd_sel_q;
        count_d  = count_q;

        if (wa) begin
            head_d = head_q + AW'(1);
        end
        if (ra) begin
            rd_sel_d = tail_q;
            tail_d   = tail_q + AW'(1);
        end

        case ({wa, ra})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            rd_sel_q <= '0;
            count_q  <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            rd_sel_q <= rd_sel_d;
            count_q  <= count_d;
        end
    end

    fifo_fsm_out u_fsm (
        .clk      (clk),
        .reset_n  (reset_n),
        .wa_i     (wa),
        .ra_i     (ra),
        .wr_en_i  (wr_en),
        .rd_en_i  (rd_en),
        .full_i   (full),
        .empty_i  (empty),
        .wr_ack_o (wr_ack),
        .wr_err_o (wr_err),
        .rd_ack_o (rd_ack),
        .rd_err_o (rd_err)
    );

endmodule

// File: tb/tb_fifo_ctrl8.sv
// Scoreboard bench for fifo_ctrl8: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them as the DUT presents results.
module tb_fifo_ctrl8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] we;
    logic [2:0] rd_sel;
    logic [3:0] data_count;
    logic       full;
    logic       empty;
    logic       wr_ack;
    logic       wr_err;
    logic       rd_ack;
    logic       rd_err;

    always #5 clk = ~clk;

    fifo_ctrl8 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .we         (we),
        .rd_sel     (rd_sel),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    // Status nibble order: {wr_ack, wr_err, rd_ack, rd_err}
    localparam logic [3:0] S_WACK = 4'b1000;
    localparam logic [3:0] S_WERR = 4'b0100;
    localparam logic [3:0] S_RACK = 4'b0010;
    localparam logic [3:0] S_RERR = 4'b0001;
    localparam logic [3:0] S_RW   = 4'b1010;

    typedef struct {
        logic [3:0] st;
        logic [3:0] cnt;
    } st_exp_t;

    logic [7:0] we_q[$];
    st_exp_t    st_q[$];
    logic [2:0] sel_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [7:0] w4  [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
    logic [2:0] r4  [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [7:0] wrw [5] = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    logic [2:0] rrw [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic spurious(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT produced output with nothing expected at %0t", name, $time);
    endtask

    // Monitor: compares everything the DUT presents in the cycle against queued expectations.
    always @(negedge clk) begin : mon
        logic [3:0] st;
        st_exp_t    e;
        if (mon_en) begin
            st = {wr_ack, wr_err, rd_ack, rd_err};
            if (wr_en === 1'b1) begin
                if (we_q.size() == 0) spurious("we");
                else chk("we", 32'(we), 32'(we_q.pop_front()));
            end else begin
                chk("we_idle", 32'(we), 32'h0);
            end
            if (st !== 4'b0000) begin
                if (st_q.size() == 0) begin
                    spurious("status");
                end else begin
                    e = st_q.pop_front();
                    chk("status", 32'(st), 32'(e.st));
                    chk("data_count", 32'(data_count), 32'(e.cnt));
                    chk("full", 32'(full), 32'(e.cnt == 4'd8));
                    chk("empty", 32'(empty), 32'(e.cnt == 4'd0));
                end
                if (rd_ack === 1'b1) begin
                    if (sel_q.size() == 0) spurious("rd_sel");
                    else chk("rd_sel", 32'(rd_sel), 32'(sel_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    // Issue one request cycle and queue what the DUT must show for it.
    task automatic req(input bit w, input bit r, input logic [7:0] we_e,
                       input logic [3:0] st_e, input logic [3:0] cnt_e, input logic [2:0] sel_e);
        st_exp_t e;
        wr_en = w;
        rd_en = r;
        if (w) we_q.push_back(we_e);
        e.st  = st_e;
        e.cnt = cnt_e;
        st_q.push_back(e);
        if (st_e[1]) sel_q.push_back(sel_e);
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk_quiet(input string tag, input logic [3:0] cnt_e, input logic [2:0] sel_e);
        chk({tag, "_count"}, 32'(data_count), 32'(cnt_e));
        chk({tag, "_empty"}, 32'(empty), 32'(cnt_e == 4'd0));
        chk({tag, "_full"}, 32'(full), 32'(cnt_e == 4'd8));
        chk({tag, "_we"}, 32'(we), 32'h0);
        chk({tag, "_status"}, 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'h0);
        chk({tag, "_rd_sel"}, 32'(rd_sel), 32'(sel_e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Reset state after idling
        idle(3);
        chk_quiet("reset", 4'd0, 3'd0);

        // Fill from reset, then one rejected write
        for (int i = 0; i < 8; i++) req(1, 0, 8'h01 << i, S_WACK, 4'(i + 1), 3'd0);
        req(1, 0, 8'h00, S_WERR, 4'd8, 3'd0);
        chk("full_after_fill", 32'(full), 32'h1);
        chk("count_after_fill", 32'(data_count), 32'd8);

        // Drain, then one rejected read
        for (int i = 0; i < 8; i++) req(0, 1, 8'h00, S_RACK, 4'(7 - i), 3'(i));
        req(0, 1, 8'h00, S_RERR, 4'd0, 3'd0);
        chk("rd_sel_hold", 32'(rd_sel), 32'd7);
        chk("empty_after_drain", 32'(empty), 32'h1);

        // Wrap-around: write 6, read 6, write 4, read 4
        for (int i = 0; i < 6; i++) req(1, 0, 8'h01 << i, S_WACK, 4'(i + 1), 3'd0);
        for (int i = 0; i < 6; i++) req(0, 1, 8'h00, S_RACK, 4'(5 - i), 3'(i));
        for (int i = 0; i < 4; i++) req(1, 0, w4[i], S_WACK, 4'(i + 1), 3'd0);
        chk("count_wrap", 32'(data_count), 32'd4);
        for (int i = 0; i < 4; i++) req(0, 1, 8'h00, S_RACK, 4'(3 - i), r4[i]);

        // Simultaneous read+write with count 3 (head=2, tail=2)
        req(1, 0, 8'h04, S_WACK, 4'd1, 3'd0);
        req(1, 0, 8'h08, S_WACK, 4'd2, 3'd0);
        req(1, 0, 8'h10, S_WACK, 4'd3, 3'd0);
        for (int i = 0; i < 5; i++) req(1, 1, wrw[i], S_RW, 4'd3, rrw[i]);
        req(0, 1, 8'h00, S_RACK, 4'd2, 3'd7);
        req(0, 1, 8'h00, S_RACK, 4'd1, 3'd0);
        req(0, 1, 8'h00, S_RACK, 4'd0, 3'd1);

        // Read+write when empty: only the write is taken, no rd_err
        req(1, 1, 8'h04, S_WACK, 4'd1, 3'd0);
        req(0, 1, 8'h00, S_RACK, 4'd0, 3'd2);

        // Read+write when full: only the read is taken, no wr_err (head=3, tail=3)
        for (int i = 0; i < 8; i++) req(1, 0, 8'h01 << ((3 + i) % 8), S_WACK, 4'(i + 1), 3'd0);
        req(1, 1, 8'h00, S_RACK, 4'd7, 3'd3);
        for (int i = 0; i < 7; i++) req(0, 1, 8'h00, S_RACK, 4'(6 - i), 3'((4 + i) % 8));

        // Reset in the middle of writing (head=3, tail=3)
        for (int i = 0; i < 5; i++) req(1, 0, 8'h08 << i, S_WACK, 4'(i + 1), 3'd0);
        wr_en   = 1'b1;
        reset_n = 1'b0;
        we_q.push_back(8'h00);
        step();
        reset_n = 1'b1;
        wr_en   = 1'b0;
        chk_quiet("midreset", 4'd0, 3'd0);
        req(1, 0, 8'h01, S_WACK, 4'd1, 3'd0);
        req(0, 1, 8'h00, S_RACK, 4'd0, 3'd0);

        idle(2);
        chk("we_q_drained", 32'(we_q.size()), 32'd0);
        chk("st_q_drained", 32'(st_q.size()), 32'd0);
        chk("sel_q_drained", 32'(sel_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
